arb_seq: RTL and testbench
==========================

ARB_SEQ -- requirements
Module: arb_seq

Interface
REQ-001 Parameter: MAX_PICKS, 64, maximum squares emitted per load (1..64); a scan ends after this many accepted picks.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 load_valid  input  1  new 64-square priority set offered.
REQ-005 load_ready  output  1  block can accept a load (high only in IDLE).
REQ-006 load_prio  input  192  3-bit priority per square; square i at bits [3i+2:3i]; 0 = square not a candidate.
REQ-007 arb_prio  output  192  working priority register, drives the priority arbiter input.
REQ-008 arb_result  input  7  combinational arbiter result; [5:0] winning square, [6] = no candidate (all priorities 0).
REQ-009 out_valid  output  1  picked square offered downstream.
REQ-010 out_ready  input  1  downstream accepts the pick.
REQ-011 out_square  output  6  picked square index.
REQ-012 out_prio  output  3  priority of picked square at pick time.
REQ-013 abort  input  1  cancel current scan.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at normal scan end.
REQ-016 pick_count  output  7  picks accepted since last load; held until next load.

Function
REQ-017 States SHALL be IDLE, EVAL, OFFER, DONE, encoded in a single state register.
REQ-018 IDLE: load_ready=1; load_valid&&load_ready SHALL copy load_prio into arb_prio, clear pick_count to 0, go to EVAL.
REQ-019 EVAL (exactly one cycle): if arb_result[6]=1 or pick_count==MAX_PICKS, go to DONE; else register out_square=arb_result[5:0], out_prio=arb_prio[3*arb_result[5:0] +: 3], go to OFFER.
REQ-020 OFFER: out_valid=1; out_square/out_prio SHALL stay stable until accepted; out_valid SHALL NOT drop without acceptance except on abort or reset.
REQ-021 OFFER with out_ready=1: clear the 3 bits of arb_prio for out_square to 0, increment pick_count, go to EVAL.
REQ-022 DONE: done=1 for that single cycle, then IDLE; arb_prio retains its contents (all zero if exhausted).
REQ-023 Latency: load accepted at cycle N -> out_valid first high at N+2; pick accepted at cycle M -> next out_valid at M+2 or done at M+2.
REQ-024 Emission order SHALL be exactly the arbiter's winner order: descending priority, lowest square index on equal priority.
REQ-025 A square SHALL be emitted at most once per load; priority-0 squares SHALL never be emitted.
REQ-026 abort in EVAL, OFFER or DONE: next state IDLE, arb_prio cleared to 0, out_valid low next cycle, no done pulse; pick_count holds.
REQ-027 abort and out_ready high together in OFFER: abort wins; pick not counted, pick_count unchanged.
REQ-028 abort in IDLE SHALL have no effect; load_valid outside IDLE SHALL be ignored.
REQ-029 pick_count SHALL saturate at MAX_PICKS (never wraps).
REQ-030 out_valid, done, load_ready, busy SHALL be functions of registered state only (no combinational path from out_ready or arb_result).

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, arb_prio=0, out_square=0, out_prio=0, pick_count=0, out_valid=0, done=0, busy=0; load_ready=1 from deassertion.
REQ-032 Reset mid-scan SHALL discard the scan with no done pulse; first load accepted on first rising edge with rst_n high.

Verification
REQ-033 Load square 5=3, square 40=7, square 12=3, rest 0, out_ready always 1 -> picks (40,7),(5,3),(12,3), pick_count=3, done 2 cycles after last accept.
REQ-034 Load all zero -> EVAL then done pulse at N+2, out_valid never high, pick_count=0.
REQ-035 Load all 64 squares = 1, MAX_PICKS=4 -> picks squares 0,1,2,3 in order, then done; arb_prio squares 4..63 still 1.
REQ-036 Backpressure: out_ready low 10 cycles in OFFER -> out_valid, out_square, out_prio stable all 10 cycles; accept on 11th.
REQ-037 abort with out_ready high during 2nd OFFER of REQ-033 -> IDLE next cycle, pick_count=1, no done, arb_prio=0, new load accepted.
REQ-038 rst_n pulsed low mid-OFFER (asynchronous to clk) -> out_valid and busy fall immediately, all outputs at reset values.

Source files
------------

// File: rtl/arb_seq.sv
// Sequencer that walks an external priority arbiter: emits squares in winner
// order, clearing each accepted square from the working priority register.
module arb_seq #(
  parameter int MAX_PICKS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [191:0] load_prio,
  output logic [191:0] arb_prio,
  input  logic [6:0]   arb_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [5:0]   out_square,
  output logic [2:0]   out_prio,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [6:0]   pick_count
);

  typedef enum logic [1:0] {IDLE, EVAL, OFFER, DONE} state_t;

  localparam logic [6:0] MAX_CNT = 7'(MAX_PICKS);

  state_t       state_reg, state_next;
  logic [191:0] arb_prio_reg, arb_prio_next;
  logic [5:0]   out_square_reg, out_square_next;
  logic [2:0]   out_prio_reg, out_prio_next;
  logic [6:0]   pick_count_reg, pick_count_next;

  logic [2:0]   sq_prio [64];
  logic [191:0] pick_mask;
  logic         no_cand;
  logic         cap_reached;

  // Per-square views: priority lookup for the winner and a mask that
  // removes the currently offered square when it is accepted.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_square
      assign sq_prio[gi]           = arb_prio_reg[3*gi +: 3];
      assign pick_mask[3*gi +: 3]  = (out_square_reg == 6'(gi)) ? 3'b000 : 3'b111;
    end
  endgenerate

  assign no_cand     = arb_result[6];
  assign cap_reached = (pick_count_reg >= MAX_CNT);

  always_comb begin
    state_next      = state_reg;
    arb_prio_next   = arb_prio_reg;
    out_square_next = out_square_reg;
    out_prio_next   = out_prio_reg;
    pick_count_next = pick_count_reg;

    case (state_reg)
      IDLE: begin
        if (load_valid) begin
          arb_prio_next   = load_prio;
          pick_count_next = 7'd0;
          state_next      = EVAL;
        end
      end
      EVAL: begin
        if (abort) begin
          arb_prio_next = '0;
          state_next    = IDLE;
        end else if (no_cand || cap_reached) begin
          state_next = DONE;
        end else begin
          out_square_next = arb_result[5:0];
          out_prio_next   = sq_prio[arb_result[5:0]];
          state_next      = OFFER;
        end
      end
      OFFER: begin
        // Abort takes precedence over a simultaneous accept.
        if (abort) begin
          arb_prio_next = '0;
          state_next    = IDLE;
        end else if (out_ready) begin
          arb_prio_next = arb_prio_reg & pick_mask;
          if (pick_count_reg < MAX_CNT) begin
            pick_count_next = pick_count_reg + 7'd1;
          end
          state_next = EVAL;
        end
      end
      DONE: begin
        if (abort) begin
          arb_prio_next = '0;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      arb_prio_reg   <= '0;
      out_square_reg <= '0;
      out_prio_reg   <= '0;
      pick_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      arb_prio_reg   <= arb_prio_next;
      out_square_reg <= out_square_next;
      out_prio_reg   <= out_prio_next;
      pick_count_reg <= pick_count_next;
    end
  end

  // Handshake/status outputs decode the state register only.
  assign load_ready = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign out_valid  = (state_reg == OFFER);
  assign done       = (state_reg == DONE);
  assign arb_prio   = arb_prio_reg;
  assign out_square = out_square_reg;
  assign out_prio   = out_prio_reg;
  assign pick_count = pick_count_reg;

endmodule

// File: tb/tb_arb_seq.sv
// Randomized bench for arb_seq: a behavioural arbiter drives arb_result and a
// sorted-key reference model predicts the pick order, latency and residue.
module tb_arb_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid, load_ready, out_valid, out_ready, abort, busy, done;
  logic [191:0] load_prio, arb_prio;
  logic [6:0]   arb_result, pick_count;
  logic [5:0]   out_square;
  logic [2:0]   out_prio;

  logic         load_valid_b, load_ready_b, out_valid_b, out_ready_b, abort_b, busy_b, done_b;
  logic [191:0] load_prio_b, arb_prio_b;
  logic [6:0]   arb_result_b, pick_count_b;
  logic [5:0]   out_square_b;
  logic [2:0]   out_prio_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Environment arbiter: highest priority wins, lowest index breaks ties.
  function automatic logic [6:0] arbiter(input logic [191:0] p);
    logic [6:0] res;
    logic       found;
    res   = 7'h40;
    found = 1'b0;
    for (int pr = 7; pr >= 1; pr--) begin
      for (int i = 0; i < 64; i++) begin
        if (!found && p[3*i +: 3] == 3'(pr)) begin
          res   = {1'b0, 6'(i)};
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  assign arb_result   = arbiter(arb_prio);
  assign arb_result_b = arbiter(arb_prio_b);

  arb_seq #(.MAX_PICKS(64)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_prio(load_prio), .arb_prio(arb_prio), .arb_result(arb_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_square(out_square),
    .out_prio(out_prio), .abort(abort), .busy(busy), .done(done),
    .pick_count(pick_count)
  );

  arb_seq #(.MAX_PICKS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid_b), .load_ready(load_ready_b),
    .load_prio(load_prio_b), .arb_prio(arb_prio_b), .arb_result(arb_result_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_square(out_square_b),
    .out_prio(out_prio_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .pick_count(pick_count_b)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] rand_vec(input int density);
    logic [191:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 99) < density) v[3*i +: 3] = 3'($urandom_range(1, 7));
    end
    return v;
  endfunction

  task automatic do_load(input logic [191:0] p);
    int waited;
    waited = 0;
    while (!load_ready && waited < 20) begin
      tick;
      waited++;
    end
    check("load_ready", load_ready, 1);
    load_valid = 1'b1;
    load_prio  = p;
    tick;
    load_valid = 1'b0;
    check("busy_after_load", busy, 1);
    check("pick_count_cleared", pick_count, 0);
    check("eval_no_valid", out_valid, 0);
  endtask

  // stall_max < 0 forces a 10-cycle stall before every accept.
  task automatic run_scan(input logic [191:0] p, input int stall_max, input int abort_at);
    int           keys[$];
    logic [191:0] resid;
    int           sq, pr, stall, npick;
    logic         aborted;
    keys = {};
    for (int i = 0; i < 64; i++) begin
      if (p[3*i +: 3] != 3'd0) keys.push_back((7 - int'(p[3*i +: 3])) * 64 + i);
    end
    keys.sort();
    npick   = keys.size();
    resid   = p;
    aborted = 1'b0;
    do_load(p);
    tick;
    for (int idx = 0; idx < npick; idx++) begin
      sq = keys[idx] % 64;
      pr = 7 - keys[idx] / 64;
      check("offer_valid", out_valid, 1);
      check("offer_square", out_square, sq);
      check("offer_prio", out_prio, pr);
      $display("pick %0d: square=%0d prio=%0d count=%0d", idx, out_square, out_prio, pick_count);
      if (idx == abort_at) begin
        abort     = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        tick;
        abort     = 1'b0;
        out_ready = 1'b0;
        check("abort_idle", load_ready, 1);
        check("abort_valid", out_valid, 0);
        check("abort_no_done", done, 0);
        check("abort_count", pick_count, idx);
        check("abort_prio_clear", arb_prio, 0);
        aborted = 1'b1;
        break;
      end
      stall = (stall_max < 0) ? 10 : $urandom_range(0, stall_max);
      repeat (stall) begin
        out_ready  = 1'b0;
        load_valid = 1'($urandom_range(0, 1));
        load_prio  = rand_vec(50);
        tick;
        check("stall_valid", out_valid, 1);
        check("stall_square", out_square, sq);
        check("stall_prio", out_prio, pr);
      end
      load_valid = 1'b0;
      out_ready  = 1'b1;
      tick;
      out_ready  = 1'b0;
      resid[3*sq +: 3] = 3'd0;
      check("eval_after_accept", out_valid, 0);
      check("count_after_accept", pick_count, idx + 1);
      tick;
    end
    if (!aborted) begin
      check("done_pulse", done, 1);
      check("done_no_valid", out_valid, 0);
      check("done_count", pick_count, npick);
      check("done_residue", arb_prio, resid);
      $display("scan done: picks=%0d", pick_count);
      tick;
      check("done_single", done, 0);
      check("back_idle", load_ready, 1);
      check("count_held", pick_count, npick);
    end
  endtask

  logic [191:0] v033, held_prio, ones, ones_resid;
  logic [6:0]   held_count;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0; load_prio = '0; out_ready = 1'b0; abort = 1'b0;
    load_valid_b = 1'b0; load_prio_b = '0; out_ready_b = 1'b0; abort_b = 1'b0;
    v033 = '0;
    v033[3*5 +: 3] = 3'd3; v033[3*40 +: 3] = 3'd7; v033[3*12 +: 3] = 3'd3;

    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", load_ready, 1);
    check("rst_prio", arb_prio, 0);
    check("rst_count", pick_count, 0);
    check("rst_square", out_square, 0);
    check("rst_oprio", out_prio, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    run_scan(v033, 0, -1);
    run_scan('0, 0, -1);
    run_scan(v033, -1, -1);
    run_scan(v033, 0, 1);
    run_scan(rand_vec(30), 2, -1);

    // Abort and load_valid-free cycles in IDLE must leave everything alone.
    held_prio  = arb_prio;
    held_count = pick_count;
    abort = 1'b1;
    tick; tick;
    abort = 1'b0;
    check("idle_abort_ready", load_ready, 1);
    check("idle_abort_prio", arb_prio, held_prio);
    check("idle_abort_count", pick_count, held_count);

    // Asynchronous reset in the middle of an offer.
    do_load(v033);
    tick;
    check("pre_rst_offer", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", load_ready, 1);
    check("arst_prio", arb_prio, 0);
    check("arst_count", pick_count, 0);
    check("arst_square", out_square, 0);
    check("arst_oprio", out_prio, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(v033, 1, -1);

    run_scan(rand_vec(100), 0, -1);
    for (int t = 0; t < 15; t++) begin
      run_scan(rand_vec($urandom_range(3, 40)), 3,
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    // MAX_PICKS=4 instance with every square at priority 1.
    ones = '0;
    for (int i = 0; i < 64; i++) ones[3*i +: 3] = 3'd1;
    ones_resid = ones;
    ones_resid[11:0] = '0;
    load_valid_b = 1'b1; load_prio_b = ones; out_ready_b = 1'b1;
    tick;
    load_valid_b = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      check("cap_valid", out_valid_b, 1);
      check("cap_square", out_square_b, k);
      check("cap_prio", out_prio_b, 1);
      $display("cap pick %0d: square=%0d", k, out_square_b);
      tick;
      check("cap_count", pick_count_b, k + 1);
      tick;
    end
    check("cap_done", done_b, 1);
    check("cap_no_valid", out_valid_b, 0);
    check("cap_final_count", pick_count_b, 4);
    check("cap_residue", arb_prio_b, ones_resid);
    tick;
    check("cap_idle", load_ready_b, 1);
    out_ready_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
